// File: rtl/serial_sub_ctrl_pkg.sv
// Shared state encodings and sizing helpers for the bit-serial subtractor controller.
// Encoding 2'd3 is unused and recovers to S_IDLE.
package serial_sub_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter must hold WIDTH after the final increment without wrapping.
    function automatic int cnt_width(input int width);
        return (width < 1) ? 1 : $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_cell.sv
// One-bit full-subtractor cell: d = x - y - bin, bout set when the bit borrows.
// Purely combinational; the controller provides all sequencing.
module bit_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic x_eq_y;

    assign x_eq_y = ~(x ^ y);
    assign d      = x ^ y ^ bin;
    assign bout   = (~x & y) | (x_eq_y & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one bit_sub_cell walked LSB-first over the operands.
// Latency WIDTH+1 edges from accepted start to done; start is ignored unless ready.
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               brw_q, brw_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;

    logic               cell_d;
    logic               cell_bout;
    logic               cnt_last;
    logic [WIDTH-1:0]   res_shift;

    bit_sub_cell u_cell (
        .x    (opa_q[0]),
        .y    (opb_q[0]),
        .bin  (brw_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign cnt_last = (cnt_q == CNT_LAST);

    // New difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    always_comb begin
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = cell_d;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (cnt_last) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            S_IDLE: ready = 1'b1;
            S_RUN:  busy  = 1'b1;
            S_DONE: done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Datapath next-state
    always_comb begin
        cnt_d  = cnt_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        res_d  = res_q;
        brw_d  = brw_q;
        diff_d = diff_q;
        bout_d = bout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d = a;
                    opb_d = b;
                    brw_d = bin;
                    cnt_d = '0;
                end
            end
            S_RUN: begin
                opa_d = opa_q >> 1;
                opb_d = opb_q >> 1;
                brw_d = cell_bout;
                res_d = res_shift;
                cnt_d = cnt_q + CNT_W'(1);
                // Published result only changes here, so diff/bout stay stable through a later RUN.
                if (cnt_last) begin
                    diff_d = res_shift;
                    bout_d = cell_bout;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            res_q  <= '0;
            brw_q  <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            res_q  <= res_d;
            brw_q  <= brw_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: WIDTH=8 instance driven through a result scoreboard,
// plus a WIDTH=1 instance exercised over its full truth table.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       bin;
    logic       ready, busy, done;
    logic [7:0] diff;
    logic       bout;

    logic       start1;
    logic [0:0] a1, b1;
    logic       bin1;
    logic       ready1, busy1, done1;
    logic [0:0] diff1;
    logic       bout1;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .ready(ready), .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .ready(ready1), .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    // Scoreboard consumer and handshake invariant, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((int'(ready) + int'(busy) + int'(done)) != 1) begin
                errors++;
                $display("FAIL onehot: ready=%b busy=%b done=%b, required exactly one high", ready, busy, done);
            end
            checks++;
            if ((int'(ready1) + int'(busy1) + int'(done1)) != 1) begin
                errors++;
                $display("FAIL onehot_w1: ready=%b busy=%b done=%b, required exactly one high", ready1, busy1, done1);
            end
            if (done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: diff=%h bout=%b with no pending request", diff, bout);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({bout, diff} !== e) begin
                        errors++;
                        $display("FAIL result: got bout=%b diff=%h, required bout=%b diff=%h", bout, diff, e[8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tbin);
        int n;
        logic [8:0] ref9;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: ready=%b, required 1", ready);
        end
        a = ta; b = tbv; bin = tbin; start = 1'b1;
        ref9 = {1'b0, ta} - {1'b0, tbv} - {8'd0, tbin};
        exp_q.push_back(ref9);
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL latency: done after %0d edges, required 9", n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready, busy, done, bout, diff} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: ready=%b busy=%b done=%b bout=%b diff=%h, required 1 0 0 0 00",
                     ready, busy, done, bout, diff);
        end
        checks++;
        if ({ready1, busy1, done1, bout1, diff1} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_state_w1: ready=%b busy=%b done=%b bout=%b diff=%b, required 1 0 0 0 0",
                     ready1, busy1, done1, bout1, diff1);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run_op(8'h35, 8'h12, 1'b0);
        run_op(8'h00, 8'h01, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1);
    endtask

    task automatic test_hold;
        int n;
        run_op(8'h35, 8'h12, 1'b0);
        a = 8'h00; b = 8'h01; bin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h1FF);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, bout, diff} !== {1'b1, 1'b0, 8'h23}) begin
            errors++;
            $display("FAIL hold_in_run: busy=%b bout=%b diff=%h, required 1 0 23", busy, bout, diff);
        end
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int seen, cyc, last;
        seen = 0; cyc = 0; last = 0;
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        repeat (3) exp_q.push_back(9'h00F);
        while (seen < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                checks++;
                if (seen == 0 && cyc != 9) begin
                    errors++;
                    $display("FAIL b2b_first: done at %0d, required 9", cyc);
                end else if (seen > 0 && (cyc - last) != 10) begin
                    errors++;
                    $display("FAIL b2b_interval: %0d cycles, required 10", cyc - last);
                end
                last = cyc;
                seen++;
                if (seen == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (seen != 3) begin
            errors++;
            $display("FAIL b2b_timeout: saw %0d results, required 3", seen);
        end
        @(negedge clk);
    endtask

    task automatic test_repulse;
        int n;
        a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h023);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL repulse_not_queued: ready=%b, required 1", ready);
        end
    endtask

    task automatic test_abort;
        a = 8'h55; b = 8'h22; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({ready, busy, done, bout, diff} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL abort_reset: ready=%b busy=%b done=%b bout=%b diff=%h, required 1 0 0 0 00",
                     ready, busy, done, bout, diff);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(8'h80, 8'h7F, 1'b0);
    endtask

    task automatic test_width1;
        logic [7:0] dtab, btab;
        logic [2:0] v;
        dtab = 8'b1001_0110;
        btab = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            checks++;
            if ({busy1, done1} !== 2'b10) begin
                errors++;
                $display("FAIL w1_run: case %0d busy=%b done=%b, required 1 0", i, busy1, done1);
            end
            @(negedge clk);
            checks++;
            if ({done1, diff1, bout1} !== {1'b1, dtab[i], btab[i]}) begin
                errors++;
                $display("FAIL w1_result: case %0d done=%b diff=%b bout=%b, required 1 %b %b",
                         i, done1, diff1, bout1, dtab[i], btab[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 1000; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_drain;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_repulse();
        test_abort();
        test_width1();
        test_random();
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
